// File: rtl/uarc_bus_sender.sv
// UARC bus sender: a small command FIFO feeding a registered receiver-side bus.
// Each strobe retires on its matching ack. A kill or an ack timeout inserts a one-cycle enable gap.
module uarc_bus_sender #(
  parameter int unsigned WORD_MAG       = 5,
  parameter int unsigned CMD_ADDR_WIDTH = 2,
  parameter int unsigned TIMEOUT        = 64,
  localparam int unsigned W             = 1 << WORD_MAG
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic [W-1:0] cmd_self_permission,
  input  logic [W-1:0] cmd_self_address,
  input  logic [W-1:0] cmd_incept_permission,
  input  logic [W-1:0] cmd_incept_address,
  output logic         bus_enable,
  output logic         bus_kill,
  output logic         bus_incept,
  output logic         bus_send,
  output logic         bus_stream,
  output logic [W-1:0] bus_data,
  output logic [W-1:0] bus_self_permission,
  output logic [W-1:0] bus_self_address,
  output logic [W-1:0] bus_incept_permission,
  output logic [W-1:0] bus_incept_address,
  input  logic         bus_kill_ack,
  input  logic         bus_incept_ack,
  input  logic         bus_send_ack,
  input  logic         bus_stream_ack,
  output logic         busy,
  output logic         timeout_error,
  input  logic         err_clear,
  output logic [W-1:0] retired_count
);
  localparam int unsigned DEPTH   = 1 << CMD_ADDR_WIDTH;
  localparam int unsigned CNT_W   = CMD_ADDR_WIDTH + 1;
  localparam int unsigned ENTRY_W = 2 + 5 * W;
  localparam int unsigned WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_e;

  state_e                    state_q;
  logic [ENTRY_W-1:0]        mem_q [DEPTH];
  logic [CMD_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic [3:0]                strobe_q;
  logic                      enable_q;
  logic [W-1:0]              data_q, self_perm_q, self_addr_q, inc_perm_q, inc_addr_q;
  logic                      err_q;
  logic [W-1:0]              retired_q;
  logic [WAIT_W-1:0]         wait_q;

  logic               empty_c, full_c, push_c, pop_c;
  logic               pending_c, complete_c, expire_c;
  logic [3:0]         acks_c;
  logic [ENTRY_W-1:0] head_c;

  // Strobe bit order {stream, send, incept, kill} matches the op encoding.
  always_comb begin
    empty_c    = (count_q == '0);
    full_c     = (count_q == CNT_W'(DEPTH));
    push_c     = cmd_valid && !full_c;
    acks_c     = {bus_stream_ack, bus_send_ack, bus_incept_ack, bus_kill_ack};
    pending_c  = |strobe_q;
    complete_c = |(strobe_q & acks_c);
    expire_c   = (TIMEOUT != 0) && pending_c && !complete_c &&
                 (wait_q == WAIT_W'(TIMEOUT - 1));
    head_c     = mem_q[rd_ptr_q];
    pop_c      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_GAP: pop_c = !empty_c;
      ST_ACTIVE:       pop_c = !empty_c && (!pending_c || (complete_c && !strobe_q[0]));
      default:         pop_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_self_permission, cmd_self_address,
                          cmd_incept_permission, cmd_incept_address};
    end
  end

  // Leaving GAP with work queued issues directly, so the gap is exactly one enable-low cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      strobe_q    <= '0;
      enable_q    <= 1'b0;
      data_q      <= '0;
      self_perm_q <= '0;
      self_addr_q <= '0;
      inc_perm_q  <= '0;
      inc_addr_q  <= '0;
      err_q       <= 1'b0;
      retired_q   <= '0;
      wait_q      <= '0;
    end else begin
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (push_c) wr_ptr_q <= wr_ptr_q + CMD_ADDR_WIDTH'(1);
      if (complete_c) retired_q <= retired_q + W'(1);
      if (expire_c) err_q <= 1'b1;
      else if (err_clear) err_q <= 1'b0;

      if (pop_c) begin
        rd_ptr_q    <= rd_ptr_q + CMD_ADDR_WIDTH'(1);
        strobe_q    <= 4'b0001 << head_c[ENTRY_W-1 -: 2];
        data_q      <= head_c[5*W-1 -: W];
        self_perm_q <= head_c[4*W-1 -: W];
        self_addr_q <= head_c[3*W-1 -: W];
        inc_perm_q  <= head_c[2*W-1 -: W];
        inc_addr_q  <= head_c[W-1:0];
        enable_q    <= 1'b1;
        wait_q      <= '0;
        state_q     <= ST_ACTIVE;
      end else begin
        unique case (state_q)
          ST_ACTIVE: begin
            if ((complete_c && strobe_q[0]) || expire_c) begin
              strobe_q <= '0;
              enable_q <= 1'b0;
              state_q  <= ST_GAP;
            end else if (complete_c) begin
              strobe_q <= '0;
            end else if (pending_c) begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end
          ST_GAP:  state_q <= ST_IDLE;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign cmd_ready             = !full_c;
  assign busy                  = !empty_c || pending_c;
  assign bus_enable            = enable_q;
  assign bus_kill              = strobe_q[0];
  assign bus_incept            = strobe_q[1];
  assign bus_send              = strobe_q[2];
  assign bus_stream            = strobe_q[3];
  assign bus_data              = data_q;
  assign bus_self_permission   = self_perm_q;
  assign bus_self_address      = self_addr_q;
  assign bus_incept_permission = inc_perm_q;
  assign bus_incept_address    = inc_addr_q;
  assign timeout_error         = err_q;
  assign retired_count         = retired_q;
endmodule

// File: tb/tb_uarc_bus_sender.sv
// Bench for uarc_bus_sender: command vector table, scoreboard of expected transfers
// checked on every acked strobe, and hand sequences for kill gap, timeout, full FIFO and reset.
module tb_uarc_bus_sender;
  localparam int unsigned W       = 32;
  localparam int unsigned TIMEOUT = 64;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] data, sp, sa, ip, ia;
  } cmd_t;

  typedef struct {
    cmd_t       cmd;
    logic [3:0] exp_strobe;
  } vec_t;

  logic         clk = 1'b0, reset = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [1:0]   cmd_op = '0;
  logic [W-1:0] cmd_data = '0, cmd_sp = '0, cmd_sa = '0, cmd_ip = '0, cmd_ia = '0;
  logic         bus_enable, bus_kill, bus_incept, bus_send, bus_stream;
  logic [W-1:0] bus_data, bus_sp, bus_sa, bus_ip, bus_ia;
  logic         kill_ack = 1'b0, incept_ack = 1'b0, send_ack = 1'b0, stream_ack = 1'b0;
  logic         busy, timeout_error, err_clear = 1'b0;
  logic [W-1:0] retired_count;

  int   tests = 0, fails = 0, exp_retired = 0;
  cmd_t sb[$];
  vec_t tbl[8];

  uarc_bus_sender #(.WORD_MAG(5), .CMD_ADDR_WIDTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_self_permission(cmd_sp), .cmd_self_address(cmd_sa),
    .cmd_incept_permission(cmd_ip), .cmd_incept_address(cmd_ia),
    .bus_enable(bus_enable), .bus_kill(bus_kill), .bus_incept(bus_incept),
    .bus_send(bus_send), .bus_stream(bus_stream), .bus_data(bus_data),
    .bus_self_permission(bus_sp), .bus_self_address(bus_sa),
    .bus_incept_permission(bus_ip), .bus_incept_address(bus_ia),
    .bus_kill_ack(kill_ack), .bus_incept_ack(incept_ack),
    .bus_send_ack(send_ack), .bus_stream_ack(stream_ack),
    .busy(busy), .timeout_error(timeout_error), .err_clear(err_clear),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t mk(input logic [1:0] op, input logic [W-1:0] d);
    cmd_t c;
    c.op = op;
    c.data = d;
    c.sp = d ^ 32'h1111_0000;
    c.sa = d + 32'h0000_0100;
    c.ip = ~d;
    c.ia = {d[15:0], d[31:16]};
    return c;
  endfunction

  task automatic push(input cmd_t c, input bit retire);
    check("push_ready", 160'(cmd_ready), 160'(1));
    cmd_valid = 1'b1;
    cmd_op = c.op; cmd_data = c.data;
    cmd_sp = c.sp; cmd_sa = c.sa; cmd_ip = c.ip; cmd_ia = c.ia;
    step();
    cmd_valid = 1'b0;
    if (retire) sb.push_back(c);
  endtask

  task automatic set_acks(input logic [3:0] a);
    {stream_ack, send_ack, incept_ack, kill_ack} = a;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    cmd_valid = 1'b0;
    err_clear = 1'b0;
    set_acks(4'b0000);
    sb.delete();
    exp_retired = 0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Scoreboard: a strobe meeting its ack here retires at the next rising edge.
  always @(negedge clk) begin
    logic [3:0] s, a;
    cmd_t e;
    s = {bus_stream, bus_send, bus_incept, bus_kill};
    a = {stream_ack, send_ack, incept_ack, kill_ack};
    if (!reset && (|(s & a))) begin
      check("sb_has_entry", 160'(sb.size() != 0), 160'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_strobe", 160'(s), 160'(4'b0001 << e.op));
        check("sb_payload", {bus_data, bus_sp, bus_sa, bus_ip, bus_ia},
              {e.data, e.sp, e.sa, e.ip, e.ia});
        exp_retired++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{mk(2'd2, 32'd1), 4'b0100};
    tbl[1] = '{mk(2'd2, 32'd2), 4'b0100};
    tbl[2] = '{mk(2'd2, 32'd3), 4'b0100};
    tbl[3] = '{mk(2'd2, 32'd4), 4'b0100};
    tbl[4] = '{mk(2'd1, 32'h10), 4'b0010};
    tbl[5] = '{mk(2'd3, 32'h11), 4'b1000};
    tbl[6] = '{mk(2'd2, 32'h12), 4'b0100};
    tbl[7] = '{mk(2'd3, 32'h13), 4'b1000};

    reset_dut();
    check("rst_cmd_ready", 160'(cmd_ready), 160'(1));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_enable", 160'(bus_enable), 160'(0));
    check("rst_strobes", 160'({bus_stream, bus_send, bus_incept, bus_kill}), 160'(0));
    check("rst_timeout", 160'(timeout_error), 160'(0));
    check("rst_retired", 160'(retired_count), 160'(0));
    check("rst_data", 160'(bus_data), 160'(0));

    // Single send: strobe two edges after the push edge, retire on ack.
    push(mk(2'd2, 32'hA5), 1'b1);
    check("t1_no_strobe_yet", 160'(bus_send), 160'(0));
    check("t1_busy", 160'(busy), 160'(1));
    step();
    check("t1_send", 160'(bus_send), 160'(1));
    check("t1_enable", 160'(bus_enable), 160'(1));
    send_ack = 1'b1;
    step();
    send_ack = 1'b0;
    check("t1_retired", 160'(retired_count), 160'(1));
    check("t1_strobe_drop", 160'(bus_send), 160'(0));
    check("t1_enable_held", 160'(bus_enable), 160'(1));

    // Table groups with acks tied high: four consecutive strobe cycles each, no bubble.
    set_acks(4'b1110);
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 6; k++) begin
        if (k < 4) push(tbl[g*4+k].cmd, 1'b1);
        else step();
        if (k >= 1 && k <= 4) begin
          check("t2_strobe", 160'({bus_stream, bus_send, bus_incept, bus_kill}),
                160'(tbl[g*4+k-1].exp_strobe));
          check("t2_data", 160'(bus_data), 160'(tbl[g*4+k-1].cmd.data));
          check("t2_enable", 160'(bus_enable), 160'(1));
        end
        if (k == 5) check("t2_idle_strobe", 160'({bus_stream, bus_send, bus_incept, bus_kill}), 160'(0));
      end
      check("t2_retired", 160'(retired_count), 160'(exp_retired));
    end
    check("t2_total", 160'(exp_retired), 160'(9));
    set_acks(4'b0000);

    // Kill then send: one enable-low cycle after the kill retires.
    push(mk(2'd0, 32'hDEAD), 1'b1);
    push(mk(2'd2, 32'hBEEF), 1'b1);
    check("t3_kill", 160'(bus_kill), 160'(1));
    check("t3_enable", 160'(bus_enable), 160'(1));
    kill_ack = 1'b1;
    step();
    kill_ack = 1'b0;
    check("t3_gap_enable", 160'(bus_enable), 160'(0));
    check("t3_gap_kill", 160'(bus_kill), 160'(0));
    step();
    check("t3_send_enable", 160'(bus_enable), 160'(1));
    check("t3_send", 160'(bus_send), 160'(1));
    send_ack = 1'b1;
    step();
    send_ack = 1'b0;
    check("t3_retired", 160'(retired_count), 160'(11));

    // Timeout: send never acked.
    reset_dut();
    push(mk(2'd2, 32'h77), 1'b0);
    step();
    check("t4_issue", 160'(bus_send), 160'(1));
    repeat (TIMEOUT - 1) step();
    check("t4_still_waiting", 160'(bus_send), 160'(1));
    check("t4_no_err_yet", 160'(timeout_error), 160'(0));
    step();
    check("t4_strobe_drop", 160'(bus_send), 160'(0));
    check("t4_enable_drop", 160'(bus_enable), 160'(0));
    check("t4_err", 160'(timeout_error), 160'(1));
    check("t4_retired", 160'(retired_count), 160'(0));
    step();
    check("t4_err_sticky", 160'(timeout_error), 160'(1));
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("t4_err_cleared", 160'(timeout_error), 160'(0));

    // Full FIFO: one on the bus plus four queued.
    reset_dut();
    for (int i = 0; i < 5; i++) push(mk(2'd2, 32'h50 + 32'(i)), 1'b1);
    check("t5_full", 160'(cmd_ready), 160'(0));
    check("t5_busy", 160'(busy), 160'(1));
    send_ack = 1'b1;
    step();
    check("t5_ready_again", 160'(cmd_ready), 160'(1));
    repeat (6) step();
    send_ack = 1'b0;
    check("t5_drained_busy", 160'(busy), 160'(0));
    check("t5_retired", 160'(retired_count), 160'(5));
    check("t5_model_retired", 160'(retired_count), 160'(exp_retired));
    check("sb_drained", 160'(sb.size()), 160'(0));

    // Incept ignores foreign acks; async reset mid-transfer clears outputs at once.
    reset_dut();
    push(mk(2'd1, 32'hC0DE), 1'b1);
    step();
    check("t6_incept", 160'(bus_incept), 160'(1));
    set_acks(4'b1101);
    repeat (3) step();
    check("t6_incept_held", 160'(bus_incept), 160'(1));
    check("t6_no_retire", 160'(retired_count), 160'(0));
    set_acks(4'b0000);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_enable", 160'(bus_enable), 160'(0));
    check("t6_rst_strobes", 160'({bus_stream, bus_send, bus_incept, bus_kill}), 160'(0));
    check("t6_rst_busy", 160'(busy), 160'(0));
    check("t6_rst_ready", 160'(cmd_ready), 160'(1));
    check("t6_rst_data", 160'(bus_data), 160'(0));
    reset_dut();
    repeat (2) step();
    check("t6_stays_idle", 160'(bus_enable), 160'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
